// File: rtl/ebpc_pkg.sv
// Shared widths, symbol prefixes and types for the EBPC DBX compressor/decompressor pair.
// The block geometry here is 8-bit data in blocks of 8 words.
package ebpc_pkg;
    localparam int DATA_W         = 8;
    localparam int BLOCK_SIZE     = 8;
    localparam int LOG2N          = $clog2(BLOCK_SIZE);
    localparam int PLANE_W        = BLOCK_SIZE - 1;
    localparam int N              = BLOCK_SIZE;
    localparam int FIVE           = 5;
    localparam int FIVE_PLUS_LOGN = 5 + LOG2N;
    localparam int MAX_SYMB_LEN   = (N > FIVE_PLUS_LOGN) ? N : FIVE_PLUS_LOGN;
    localparam int LEN_W          = $clog2(MAX_SYMB_LEN + 1);
    localparam int CNT_W          = $clog2(DATA_W + 1);

    typedef logic [LEN_W-1:0]   symb_len_t;
    typedef logic [LOG2N-1:0]   pos_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [PLANE_W-1:0] plane_t;

    localparam logic [4:0] ALL_ONES          = 5'b00000;
    localparam logic [4:0] DBXZ_DBPNZ        = 5'b00001;
    localparam logic [4:0] TWO_ONES_PREFIX   = 5'b00010;
    localparam logic [4:0] SINGLE_ONE_PREFIX = 5'b00011;

    typedef struct packed {
        plane_t    dbx;
        logic      dbp_zero;
        symb_len_t len;
        logic      err;
    } dbx_dec_t;

    typedef enum logic {COLLECT, OUTPUT} state_t;
endpackage

// File: rtl/dbx_symbol_decoder.sv
// Combinational decode of one DBX symbol from the left-aligned bit-stream window.
// Malformed symbols decode to an all-zero DBX and flag err.
module dbx_symbol_decoder
    import ebpc_pkg::*;
(
    input  logic [MAX_SYMB_LEN-1:0] symb_i,
    input  logic                    zero_i,
    output dbx_dec_t                dec_o
);
    localparam plane_t TOP_ONE     = plane_t'(1) << (PLANE_W - 1);
    localparam plane_t TOP_TWO     = TOP_ONE | (TOP_ONE >> 1);
    localparam pos_t   MAX_POS_ONE = pos_t'(PLANE_W - 1);
    localparam pos_t   MAX_POS_TWO = pos_t'(PLANE_W - 2);

    logic [4:0] prefix;
    pos_t       pos;

    assign prefix = symb_i[MAX_SYMB_LEN-1 -: 5];
    assign pos    = symb_i[MAX_SYMB_LEN-6 -: LOG2N];

    always_comb begin
        dec_o = '0;
        if (zero_i) begin
            dec_o.len = '0;
        end else if (symb_i[MAX_SYMB_LEN-1]) begin
            dec_o.dbx = symb_i[MAX_SYMB_LEN-2 -: PLANE_W];
            dec_o.len = symb_len_t'(N);
        end else begin
            dec_o.len = symb_len_t'(FIVE);
            case (prefix)
                ALL_ONES:   dec_o.dbx      = '1;
                DBXZ_DBPNZ: dec_o.dbp_zero = 1'b1;
                // A bad position still occupies the full prefix+pos field in the stream.
                SINGLE_ONE_PREFIX: begin
                    dec_o.len = symb_len_t'(FIVE_PLUS_LOGN);
                    if (pos > MAX_POS_ONE) dec_o.err = 1'b1;
                    else                   dec_o.dbx = TOP_ONE >> pos;
                end
                TWO_ONES_PREFIX: begin
                    dec_o.len = symb_len_t'(FIVE_PLUS_LOGN);
                    if (pos > MAX_POS_TWO) dec_o.err = 1'b1;
                    else                   dec_o.dbx = TOP_TWO >> pos;
                end
                default: dec_o.err = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/dbx_decompressor.sv
// Rebuilds DBX planes from decoded symbols (MSB plane first), integrates them into
// bit-planes and presents the whole block with a valid/ready handshake.
module dbx_decompressor
    import ebpc_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [MAX_SYMB_LEN-1:0]       symb_i,
    input  logic                          zero_i,
    input  logic                          symb_valid_i,
    output logic                          symb_ready_o,
    output symb_len_t                     len_o,
    output logic [0:DATA_W][PLANE_W-1:0]  dbp_o,
    output logic                          dbp_valid_o,
    input  logic                          dbp_ready_i,
    output logic                          err_o
);
    localparam cnt_t CNT_INIT = cnt_t'(DATA_W);

    state_t   state, state_nxt;
    cnt_t     cnt;
    plane_t   prev;
    plane_t   plane;
    dbx_dec_t dec;
    logic     accept;

    dbx_symbol_decoder u_dec (
        .symb_i (symb_i),
        .zero_i (zero_i),
        .dec_o  (dec)
    );

    assign len_o  = dec.len;
    assign plane  = dec.dbp_zero ? '0 : (dec.dbx ^ prev);
    assign accept = symb_valid_i && (state == COLLECT) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= COLLECT;
        else       state <= state_nxt;
    end

    // Ready depends only on state and reset, never on dbp_ready_i.
    always_comb begin
        state_nxt    = state;
        symb_ready_o = 1'b0;
        dbp_valid_o  = 1'b0;
        case (state)
            COLLECT: begin
                symb_ready_o = !rst_i;
                if (accept && cnt == '0) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                dbp_valid_o = !rst_i;
                if (dbp_ready_i) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= CNT_INIT;
            prev  <= '0;
            dbp_o <= '0;
            err_o <= 1'b0;
        end else begin
            err_o <= accept && dec.err;
            if (accept) begin
                for (int k = 0; k <= DATA_W; k++)
                    if (cnt == cnt_t'(k)) dbp_o[k] <= plane;
                prev <= plane;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else if (dbp_valid_o && dbp_ready_i) begin
                cnt  <= CNT_INIT;
                prev <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dbx_decompressor.sv
// Scenario bench for dbx_decompressor: directed cases with fixed expectations and
// random blocks checked against a plain arithmetic model of the symbol rules.
module tb_dbx_decompressor;
    import ebpc_pkg::*;

    localparam int PW = BLOCK_SIZE - 1;
    localparam int NP = DATA_W + 1;
    typedef logic [0:DATA_W][PW-1:0] planes_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [MAX_SYMB_LEN-1:0] symb = '0;
    logic                    zero = 1'b0;
    logic                    symb_valid = 1'b0;
    logic                    symb_ready;
    symb_len_t               len;
    planes_t                 dbp;
    logic                    dbp_valid;
    logic                    dbp_ready = 1'b0;
    logic                    err;

    always #5 clk = ~clk;

    dbx_decompressor dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .symb_i       (symb),
        .zero_i       (zero),
        .symb_valid_i (symb_valid),
        .symb_ready_o (symb_ready),
        .len_o        (len),
        .dbp_o        (dbp),
        .dbp_valid_o  (dbp_valid),
        .dbp_ready_i  (dbp_ready),
        .err_o        (err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] b_symb [NP];
    logic       b_zero [NP];
    int         obs_len [NP];
    logic       obs_err [NP];
    planes_t    obs_dbp;
    logic       obs_valid, obs_early, obs_timeout;
    int         exp_len [NP];
    logic       exp_err [NP];
    planes_t    exp_dbp;

    function automatic void model_dec(input logic z, input logic [7:0] s,
                                      output int dbx, output bit dz, output int ln, output bit e);
        int pfx, pos;
        dbx = 0; dz = 0; ln = 0; e = 0;
        if (z) return;
        if (s[7]) begin dbx = int'(s & 8'h7f); ln = BLOCK_SIZE; return; end
        pfx = int'(s >> 3);
        pos = int'(s & 8'h07);
        ln  = 5;
        if (pfx == int'(ALL_ONES)) dbx = (1 << PW) - 1;
        else if (pfx == int'(DBXZ_DBPNZ)) dz = 1;
        else if (pfx == int'(SINGLE_ONE_PREFIX)) begin
            ln = 5 + LOG2N;
            if (pos <= PW - 1) dbx = 1 << (PW - 1 - pos); else e = 1;
        end else if (pfx == int'(TWO_ONES_PREFIX)) begin
            ln = 5 + LOG2N;
            if (pos <= PW - 2) dbx = 3 << (PW - 2 - pos); else e = 1;
        end else e = 1;
    endfunction

    function automatic void model_block();
        int prv, d, dbx, ln;
        bit dz, e;
        prv = 0;
        for (int i = 0; i < NP; i++) begin
            model_dec(b_zero[i], b_symb[i], dbx, dz, ln, e);
            d = dz ? 0 : (dbx ^ prv);
            exp_dbp[DATA_W-i] = PW'(d);
            exp_len[i] = ln;
            exp_err[i] = e;
            prv = d;
        end
    endfunction

    function automatic logic [7:0] pfx_symb(input logic [4:0] p, input int pos);
        logic [2:0] ps;
        ps = 3'(pos);
        return {p, ps};
    endfunction

    task automatic clear_block();
        for (int i = 0; i < NP; i++) begin b_symb[i] = '0; b_zero[i] = 1'b1; end
    endtask

    task automatic gen_random();
        for (int i = 0; i < NP; i++) begin
            b_zero[i] = 1'b0;
            case ($urandom_range(0, 7))
                0: begin b_zero[i] = 1'b1; b_symb[i] = 8'($urandom); end
                1: b_symb[i] = {1'b1, 7'($urandom)};
                2: b_symb[i] = pfx_symb(ALL_ONES, 0);
                3: b_symb[i] = pfx_symb(DBXZ_DBPNZ, 0);
                4, 5: b_symb[i] = pfx_symb(SINGLE_ONE_PREFIX, $urandom_range(0, 6));
                6: b_symb[i] = pfx_symb(TWO_ONES_PREFIX, $urandom_range(0, 5));
                default: b_symb[i] = pfx_symb(5'($urandom_range(4, 15)), $urandom_range(0, 7));
            endcase
        end
        model_block();
    endtask

    // Drives the first n symbols of the block and records what the DUT reported.
    task automatic run_block(input int n, input bit holes);
        int idx, last;
        idx = 0; last = -1;
        obs_timeout = 0; obs_early = 0; obs_valid = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (last >= 0) begin
                obs_err[last] = err;
                if (last == NP - 1) begin obs_valid = dbp_valid; obs_dbp = dbp; end
            end
            if (last != NP - 1 && dbp_valid) obs_early = 1;
            last = -1;
            if (idx >= n) begin symb_valid = 1'b0; break; end
            if (holes && $urandom_range(0, 3) == 0) symb_valid = 1'b0;
            else begin
                symb_valid = 1'b1; symb = b_symb[idx]; zero = b_zero[idx];
                #1;
                if (symb_ready) begin obs_len[idx] = int'(len); last = idx; idx++; end
            end
        end
        symb_valid = 1'b0;
        if (idx < n) obs_timeout = 1;
    endtask

    task automatic release_out(input int delay);
        repeat (delay) @(negedge clk);
        @(negedge clk) dbp_ready = 1'b1;
        @(negedge clk) dbp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (symb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", symb_ready); end
        checks++; if (dbp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dbp_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (dbp !== '0) begin errors++; $display("FAIL reset_dbp: got %h want 0", dbp); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (symb_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", symb_ready); end
    endtask

    task automatic test_zero_block();
        clear_block();
        run_block(NP, 0);
        checks++; if (obs_timeout || obs_early || obs_valid !== 1'b1) begin errors++;
            $display("FAIL zero_valid: timeout=%0d early=%0d valid=%b want 0 0 1", obs_timeout, obs_early, obs_valid); end
        for (int i = 0; i < NP; i++) begin
            checks++; if (obs_len[i] != 0) begin errors++; $display("FAIL zero_len[%0d]: got %0d want 0", i, obs_len[i]); end
        end
        checks++; if (obs_dbp !== '0) begin errors++; $display("FAIL zero_dbp: got %h want 0", obs_dbp); end
        release_out(0);
    endtask

    task automatic test_uncompressed();
        clear_block();
        b_zero[0] = 1'b0; b_symb[0] = 8'b1_0000001;
        run_block(NP, 0);
        checks++; if (obs_len[0] != 8) begin errors++; $display("FAIL unc_len: got %0d want 8", obs_len[0]); end
        for (int p = 0; p < NP; p++) begin
            checks++; if (obs_dbp[p] !== 7'b0000001) begin errors++; $display("FAIL unc_plane[%0d]: got %h want 01", p, obs_dbp[p]); end
        end
        release_out(0);
    endtask

    task automatic test_all_ones_single();
        clear_block();
        b_zero[0] = 1'b0; b_symb[0] = pfx_symb(ALL_ONES, 0);
        b_zero[1] = 1'b0; b_symb[1] = pfx_symb(SINGLE_ONE_PREFIX, 0);
        run_block(NP, 0);
        checks++; if (obs_len[0] != 5 || obs_len[1] != 8) begin errors++;
            $display("FAIL ao_len: got %0d %0d want 5 8", obs_len[0], obs_len[1]); end
        checks++; if (obs_dbp[DATA_W] !== 7'h7f) begin errors++; $display("FAIL ao_plane8: got %h want 7f", obs_dbp[DATA_W]); end
        for (int p = 0; p < DATA_W; p++) begin
            checks++; if (obs_dbp[p] !== 7'b0111111) begin errors++; $display("FAIL ao_plane[%0d]: got %h want 3f", p, obs_dbp[p]); end
        end
        release_out(0);
    endtask

    task automatic test_two_ones_dbxz();
        clear_block();
        b_zero[0] = 1'b0; b_symb[0] = pfx_symb(TWO_ONES_PREFIX, 2);
        b_zero[DATA_W-3] = 1'b0; b_symb[DATA_W-3] = pfx_symb(DBXZ_DBPNZ, 0);
        run_block(NP, 0);
        for (int p = 0; p < NP; p++) begin
            checks++; if (obs_dbp[p] !== ((p >= 4) ? 7'b0011000 : 7'b0)) begin errors++;
                $display("FAIL two_plane[%0d]: got %h want %h", p, obs_dbp[p], (p >= 4) ? 7'b0011000 : 7'b0); end
        end
        release_out(0);
    endtask

    task automatic test_backpressure();
        planes_t held;
        gen_random();
        run_block(NP, 0);
        held = obs_dbp;
        checks++; if (obs_valid !== 1'b1 || obs_dbp !== exp_dbp) begin errors++;
            $display("FAIL bp_block: valid=%b got %h want %h", obs_valid, obs_dbp, exp_dbp); end
        symb_valid = 1'b1; zero = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (dbp_valid !== 1'b1 || symb_ready !== 1'b0 || dbp !== held) begin errors++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b dbp=%h want 1 0 %h", c, dbp_valid, symb_ready, dbp, held); end
        end
        dbp_ready = 1'b1;
        #1;
        checks++; if (symb_ready !== 1'b0) begin errors++; $display("FAIL bp_comb_ready: got %b want 0", symb_ready); end
        @(negedge clk);
        dbp_ready = 1'b0; symb_valid = 1'b0;
        checks++; if (symb_ready !== 1'b1 || dbp_valid !== 1'b0) begin errors++;
            $display("FAIL bp_after: ready=%b valid=%b want 1 0", symb_ready, dbp_valid); end
        gen_random();
        run_block(NP, 0);
        checks++; if (obs_timeout || obs_valid !== 1'b1 || obs_dbp !== exp_dbp) begin errors++;
            $display("FAIL bp_next: valid=%b got %h want %h", obs_valid, obs_dbp, exp_dbp); end
        release_out(0);
    endtask

    task automatic test_malformed();
        clear_block();
        b_zero[0] = 1'b0; b_symb[0] = 8'b1_1010011;
        b_zero[2] = 1'b0; b_symb[2] = pfx_symb(SINGLE_ONE_PREFIX, 7);
        b_zero[4] = 1'b0; b_symb[4] = pfx_symb(5'b00101, 1);
        b_zero[5] = 1'b0; b_symb[5] = pfx_symb(TWO_ONES_PREFIX, 6);
        run_block(NP, 0);
        for (int i = 0; i < NP; i++) begin
            checks++; if (obs_err[i] !== ((i == 2 || i == 4 || i == 5) ? 1'b1 : 1'b0)) begin errors++;
                $display("FAIL mal_err[%0d]: got %b want %b", i, obs_err[i], (i == 2 || i == 4 || i == 5)); end
        end
        checks++; if (obs_len[4] != 5) begin errors++; $display("FAIL mal_len: got %0d want 5", obs_len[4]); end
        for (int p = 0; p < NP; p++) begin
            checks++; if (obs_dbp[p] !== 7'b1010011) begin errors++; $display("FAIL mal_plane[%0d]: got %h want 53", p, obs_dbp[p]); end
        end
        release_out(0);
    endtask

    task automatic test_reset_midblock();
        gen_random();
        run_block(4, 0);
        @(negedge clk) rst = 1'b1;
        #1;
        checks++; if (symb_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", symb_ready); end
        @(negedge clk) rst = 1'b0;
        checks++; if (dbp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", dbp_valid); end
        gen_random();
        run_block(NP, 0);
        checks++; if (obs_timeout || obs_early || obs_valid !== 1'b1 || obs_dbp !== exp_dbp) begin errors++;
            $display("FAIL rst_mid_block: valid=%b got %h want %h", obs_valid, obs_dbp, exp_dbp); end
        release_out(0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            gen_random();
            run_block(NP, 1);
            checks++; if (obs_timeout || obs_early || obs_valid !== 1'b1) begin errors++;
                $display("FAIL rnd_valid[%0d]: timeout=%0d early=%0d valid=%b", b, obs_timeout, obs_early, obs_valid); end
            checks++; if (obs_dbp !== exp_dbp) begin errors++;
                $display("FAIL rnd_dbp[%0d]: got %h want %h", b, obs_dbp, exp_dbp); end
            for (int i = 0; i < NP; i++) begin
                checks++; if (obs_len[i] != exp_len[i] || obs_err[i] !== exp_err[i]) begin errors++;
                    $display("FAIL rnd_sym[%0d][%0d]: len %0d err %b want %0d %b", b, i, obs_len[i], obs_err[i], exp_len[i], exp_err[i]); end
            end
            release_out($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_uncompressed();
        test_all_ones_single();
        test_two_ones_dbxz();
        test_backpressure();
        test_malformed();
        test_reset_midblock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
